// File: rtl/bp_network_pkg.sv
// bp_network_pkg: shared header layout, FSM state encoding and width helpers for the memory-end network
package bp_network_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
  } state_e;
  localparam int hdr_dest_w = 4;
  localparam int hdr_src_w  = 1;
  localparam int hdr_len_w  = 2;
  localparam int hdr_pad_w  = 9;
  typedef struct packed {
    logic [hdr_dest_w-1:0] dest;
    logic [hdr_src_w-1:0]  src;
    logic [hdr_len_w-1:0]  len;
    logic [hdr_pad_w-1:0]  pad;
  } hdr_s;
  function automatic int max_flits(input int msg_w, input int flit_w);
    return (msg_w + flit_w - 1) / flit_w;
  endfunction
  function automatic int len_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_network_rr_arbiter.sv
// bp_network_rr_arbiter: round-robin arbiter, one-hot grant; priority moves past the winner on accept
module bp_network_rr_arbiter
  import bp_network_pkg::*;
#(
  parameter int num_req_p = 2,
  localparam int id_width_lp = len_width(num_req_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [num_req_p-1:0]   req_i,
  input  logic                   accept_i,
  output logic [num_req_p-1:0]   grant_o,
  output logic [id_width_lp-1:0] grant_id_o
);
  logic [id_width_lp-1:0] ptr_q, ptr_d, cand;
  logic found;
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    cand       = ptr_q;
    for (int k = 0; k < num_req_p; k++) begin
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_id_o    = cand;
      end
      cand = (cand == id_width_lp'(num_req_p - 1)) ? '0 : cand + id_width_lp'(1);
    end
    ptr_d = !accept_i ? ptr_q
          : (grant_id_o == id_width_lp'(num_req_p - 1)) ? '0
          : grant_id_o + id_width_lp'(1);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
endmodule

// File: rtl/bp_network_packetizer.sv
// bp_network_packetizer: round-robin multi-channel packetizer emitting header + LSB-first payload flits
// Optional even-parity output parity_o is built when BP_NETWORK_PACKETIZER_PARITY_EN is defined.
module bp_network_packetizer
  import bp_network_pkg::*;
#(
  parameter int num_ch_p        = 2,
  parameter int dest_id_width_p = 4,
  parameter int msg_width_p     = 64,
  parameter int flit_width_p    = 16,
  localparam int max_flits_lp   = max_flits(msg_width_p, flit_width_p),
  localparam int len_width_lp   = len_width(max_flits_lp),
  localparam int src_width_lp   = len_width(num_ch_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_ch_p-1:0]                 v_i,
  input  logic [num_ch_p*msg_width_p-1:0]     data_i,
  input  logic [num_ch_p*dest_id_width_p-1:0] dest_i,
  input  logic [num_ch_p*len_width_lp-1:0]    len_i,
  output logic [num_ch_p-1:0]                 ready_o,
  output logic                                v_o,
  output logic [flit_width_p-1:0]             data_o,
  output logic                                last_o,
  input  logic                                yumi_i
`ifdef BP_NETWORK_PACKETIZER_PARITY_EN
  , output logic                              parity_o
`endif
);
  localparam int pad_lp = flit_width_p - dest_id_width_p - src_width_lp - len_width_lp;
  localparam int buf_width_lp = max_flits_lp * flit_width_p;
  localparam logic [1:0] st_idle   = S_IDLE;
  localparam logic [1:0] st_header = S_HEADER;
  localparam logic [1:0] st_data   = S_DATA;

  if (pad_lp < 0) begin : g_width_check
    $error("flit_width_p too narrow for dest/src/len header fields");
  end

  logic [1:0]                 state_q, state_d;
  logic [len_width_lp-1:0]    cnt_q, cnt_d, len_q, len_d, len_sel;
  logic [buf_width_lp-1:0]    msg_q, msg_d;
  logic [dest_id_width_p-1:0] dest_q, dest_d;
  logic [src_width_lp-1:0]    src_q, src_d, grant_id;
  logic [num_ch_p-1:0]        grant;
  logic [flit_width_p-1:0]    hdr, flit;
  logic                       accept;

  bp_network_rr_arbiter #(.num_req_p(num_ch_p)) arb (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .req_i      (v_i),
    .accept_i   (accept),
    .grant_o    (grant),
    .grant_id_o (grant_id)
  );

  assign ready_o = (state_q == st_idle && reset_n_i) ? grant : '0;
  assign accept  = |ready_o;
  assign len_sel = len_width_lp'(len_i >> (len_width_lp * grant_id));

  always_comb begin
    msg_d   = accept ? buf_width_lp'(msg_width_p'(data_i >> (msg_width_p * grant_id))) : msg_q;
    dest_d  = accept ? dest_id_width_p'(dest_i >> (dest_id_width_p * grant_id)) : dest_q;
    src_d   = accept ? grant_id : src_q;
    len_d   = !accept ? len_q
            : (len_sel > len_width_lp'(max_flits_lp - 1)) ? len_width_lp'(max_flits_lp - 1)
            : len_sel;
    state_d = (state_q == st_idle) ? (accept ? st_header : st_idle)
            : !yumi_i ? state_q
            : (state_q == st_header) ? st_data
            : last_o ? st_idle : st_data;
    cnt_d   = (state_q == st_header) ? '0
            : (state_q == st_data && yumi_i && !last_o) ? cnt_q + len_width_lp'(1)
            : cnt_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      len_q   <= '0;
      msg_q   <= '0;
      dest_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
    end

  // Outputs derive only from registered state; buffer is zero-padded past msg_width_p
  assign hdr    = flit_width_p'({dest_q, src_q, len_q}) << pad_lp;
  assign flit   = flit_width_p'(msg_q >> (flit_width_p * cnt_q));
  assign v_o    = state_q != st_idle;
  assign last_o = state_q == st_data && cnt_q == len_q;
  assign data_o = (state_q == st_header) ? hdr : v_o ? flit : '0;

`ifdef BP_NETWORK_PACKETIZER_PARITY_EN
  assign parity_o = v_o & ^{data_o, last_o};
`endif

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule

// File: tb/tb_bp_network_packetizer.sv
// tb_bp_network_packetizer: directed self-checking bench for bp_network_packetizer (default parameters)
module tb_bp_network_packetizer;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   v_i = '0;
  logic [127:0] data_i = '0;
  logic [7:0]   dest_i = '0;
  logic [3:0]   len_i = '0;
  logic         yumi_i = 1'b0;
  logic         yumi_en = 1'b0;
  logic [1:0]   ready_o;
  logic         v_o;
  logic [15:0]  data_o;
  logic         last_o;
`ifdef BP_NETWORK_PACKETIZER_PARITY_EN
  logic         parity_o;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_network_packetizer dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v_i),
    .data_i    (data_i),
    .dest_i    (dest_i),
    .len_i     (len_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .last_o    (last_o),
    .yumi_i    (yumi_i)
`ifdef BP_NETWORK_PACKETIZER_PARITY_EN
    , .parity_o (parity_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one flit on the falling edge, then drive yumi for the coming rising edge.
  task automatic obs(input string tag, input logic ev, input logic [15:0] ed, input logic el);
    @(negedge clk);
    chk({tag, ".v"}, 64'(v_o), 64'(ev));
    chk({tag, ".data"}, 64'(data_o), 64'(ed));
    chk({tag, ".last"}, 64'(last_o), 64'(el));
`ifdef BP_NETWORK_PACKETIZER_PARITY_EN
    chk({tag, ".parity"}, 64'(parity_o), ev ? 64'(^{ed, el}) : 64'd0);
`endif
    yumi_i = yumi_en & v_o;
  endtask

  initial begin
    @(negedge clk);
    v_i = 2'b11;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    // single channel, len=3
    reset_n = 1'b1;
    v_i = 2'b01;
    dest_i = 8'h05;
    len_i = 4'h3;
    data_i[63:0] = 64'h1111_2222_3333_4444;
    yumi_en = 1'b1;
    #1;
    chk("t1_ready", 64'(ready_o), 64'd1);
    obs("t1_hdr", 1'b1, 16'h5600, 1'b0);
    v_i = 2'b00;
    obs("t1_f0", 1'b1, 16'h4444, 1'b0);
    obs("t1_f1", 1'b1, 16'h3333, 1'b0);
    obs("t1_f2", 1'b1, 16'h2222, 1'b0);
    obs("t1_f3", 1'b1, 16'h1111, 1'b1);
    obs("t1_gap", 1'b0, 16'h0000, 1'b0);
    // both channels from reset: ch0 then ch1 with one idle cycle between
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    v_i = 2'b11;
    data_i = {64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0};
    dest_i = {4'h2, 4'h1};
    len_i = 4'h0;
    #1;
    chk("t2_ready0", 64'(ready_o), 64'd1);
    obs("t2_hdr0", 1'b1, 16'h1000, 1'b0);
    #1;
    chk("t2_busy_ready", 64'(ready_o), 64'd0);
    obs("t2_d0", 1'b1, 16'h00A0, 1'b1);
    obs("t2_gap", 1'b0, 16'h0000, 1'b0);
    #1;
    chk("t2_ready1", 64'(ready_o), 64'd2);
    obs("t2_hdr1", 1'b1, 16'h2800, 1'b0);
    v_i = 2'b00;
    obs("t2_d1", 1'b1, 16'h00B1, 1'b1);
    obs("t2_end", 1'b0, 16'h0000, 1'b0);
    // len=0 on channel 0
    v_i = 2'b01;
    dest_i[3:0] = 4'h5;
    len_i[1:0] = 2'd0;
    data_i[63:0] = 64'h0000_0000_0000_ABCD;
    #1;
    chk("t3_ready", 64'(ready_o), 64'd1);
    obs("t3_hdr", 1'b1, 16'h5000, 1'b0);
    v_i = 2'b00;
    obs("t3_d", 1'b1, 16'hABCD, 1'b1);
    obs("t3_idle", 1'b0, 16'h0000, 1'b0);
    // channel 1 with three cycles of backpressure on the second data flit
    v_i = 2'b10;
    dest_i[7:4] = 4'h3;
    len_i[3:2] = 2'd3;
    data_i[127:64] = 64'h4444_3333_2222_1111;
    #1;
    chk("t4_ready", 64'(ready_o), 64'd2);
    obs("t4_hdr", 1'b1, 16'h3E00, 1'b0);
    v_i = 2'b00;
    obs("t4_f0", 1'b1, 16'h1111, 1'b0);
    yumi_en = 1'b0;
    obs("t4_f1", 1'b1, 16'h2222, 1'b0);
    obs("t4_hold1", 1'b1, 16'h2222, 1'b0);
    obs("t4_hold2", 1'b1, 16'h2222, 1'b0);
    yumi_en = 1'b1;
    obs("t4_hold3", 1'b1, 16'h2222, 1'b0);
    obs("t4_f2", 1'b1, 16'h3333, 1'b0);
    obs("t4_f3", 1'b1, 16'h4444, 1'b1);
    obs("t4_idle", 1'b0, 16'h0000, 1'b0);
    // reset during the third flit, then pointer must be back at channel 0
    v_i = 2'b01;
    len_i[1:0] = 2'd3;
    data_i[63:0] = 64'h1111_2222_3333_4444;
    #1;
    chk("t5_ready", 64'(ready_o), 64'd1);
    obs("t5_hdr", 1'b1, 16'h5600, 1'b0);
    v_i = 2'b00;
    obs("t5_f0", 1'b1, 16'h4444, 1'b0);
    obs("t5_f1", 1'b1, 16'h3333, 1'b0);
    reset_n = 1'b0;
    yumi_i = 1'b0;
    #1;
    chk("t5_rst_v", 64'(v_o), 64'd0);
    chk("t5_rst_data", 64'(data_o), 64'd0);
    chk("t5_rst_last", 64'(last_o), 64'd0);
    @(negedge clk);
    chk("t5_rst_hold_v", 64'(v_o), 64'd0);
    v_i = 2'b11;
    reset_n = 1'b1;
    #1;
    chk("t5_ready_after", 64'(ready_o), 64'd1);
    obs("t5_hdr2", 1'b1, 16'h5600, 1'b0);
    v_i = 2'b00;
    obs("t5_g0", 1'b1, 16'h4444, 1'b0);
    obs("t5_g1", 1'b1, 16'h3333, 1'b0);
    obs("t5_g2", 1'b1, 16'h2222, 1'b0);
    obs("t5_g3", 1'b1, 16'h1111, 1'b1);
    obs("t5_idle", 1'b0, 16'h0000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
